// File: rtl/vx_dvg_mask_ctl_pkg.sv
// Shared types for the divergence mask controller and the scheduler redirect path.
// Optional perf counters in vx_dvg_mask_ctl are enabled by defining DVG_CTL_PERF_EN.
package vx_dvg_mask_ctl_pkg;

  localparam int XLEN      = 32;
  localparam int DVG_WID_W = 8;

  typedef struct packed {
    logic [DVG_WID_W-1:0] wid;
    logic [XLEN-1:0]      pc;
  } dvg_redirect_t;

  function automatic logic [DVG_WID_W-1:0] dvg_wrap_inc(input logic [DVG_WID_W-1:0] idx,
                                                         input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/vx_dvg_mask_ctl_rr_arb.sv
// Round-robin arbiter for pending else-path redirects; the grant is frozen while
// the consumer is back-pressuring so wid/pc stay stable until accepted.
module vx_dvg_mask_ctl_rr_arb
  import vx_dvg_mask_ctl_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                accept,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] hold_idx_reg;
  logic             hold_reg;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    pick_idx = ptr_reg;
    cand_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand_idx = IDX_W'((int'(ptr_reg) + i) % NUM_REQS);
      if (!found && requests[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign grant_valid = |requests;
  // A held request can only be cleared by its own acceptance, so the hold is always valid.
  assign grant_idx   = hold_reg ? hold_idx_reg : pick_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= '0;
      hold_reg     <= 1'b0;
      hold_idx_reg <= '0;
    end else begin
      hold_reg     <= grant_valid && !accept;
      hold_idx_reg <= grant_idx;
      if (grant_valid && accept) begin
        ptr_reg <= IDX_W'(dvg_wrap_inc(DVG_WID_W'(grant_idx), NUM_REQS));
      end
    end
  end

endmodule

// File: rtl/vx_dvg_mask_ctl.sv
// Per-warp divergence controller: thread masks, split/join stalls and else-path redirects.
// Define DVG_CTL_PERF_EN to add the perf_dvg_splits / perf_else_redirs counters.
module vx_dvg_mask_ctl
  import vx_dvg_mask_ctl_pkg::*;
#(
  parameter int THREAD_CNT     = 4,
  parameter int WARP_CNT       = 4,
  parameter int WARP_CNT_WIDTH = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic [WARP_CNT_WIDTH-1:0]      issue_wid,
  input  logic                           split_valid,
  input  logic [WARP_CNT_WIDTH-1:0]      split_wid,
  input  logic                           split_is_dvg,
  input  logic [THREAD_CNT-1:0]          split_then_tmask,
  input  logic                           join_valid,
  input  logic                           join_is_dvg,
  input  logic                           join_is_else,
  input  logic [WARP_CNT_WIDTH-1:0]      join_wid,
  input  logic [THREAD_CNT-1:0]          join_tmask,
  input  logic [XLEN-1:0]                join_pc,
  output logic [WARP_CNT*THREAD_CNT-1:0] warp_tmask,
  output logic [WARP_CNT-1:0]            warp_stalled,
  output logic                           redir_valid,
  input  logic                           redir_ready,
  output logic [WARP_CNT_WIDTH-1:0]      redir_wid,
  output logic [XLEN-1:0]                redir_pc
`ifdef DVG_CTL_PERF_EN
  ,
  output logic [31:0]                    perf_dvg_splits,
  output logic [31:0]                    perf_else_redirs
`endif
);

  localparam logic [WARP_CNT*THREAD_CNT-1:0] TMASK_RST = (WARP_CNT*THREAD_CNT)'(1);

  logic [WARP_CNT*THREAD_CNT-1:0] tmask_reg, tmask_next;
  logic [WARP_CNT-1:0]            stalled_reg, stalled_next;
  logic [WARP_CNT-1:0]            pending_reg, pending_next;
  logic [XLEN-1:0]                pc_reg  [WARP_CNT];
  logic [XLEN-1:0]                pc_next [WARP_CNT];
  logic [WARP_CNT_WIDTH-1:0]      grant_idx;
  logic                           grant_valid;
  logic                           redir_fire;
  dvg_redirect_t                  redir_sel;

  vx_dvg_mask_ctl_rr_arb #(
    .NUM_REQS (WARP_CNT),
    .IDX_W    (WARP_CNT_WIDTH)
  ) u_rr_arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (pending_reg),
    .accept      (redir_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign redir_fire = grant_valid && redir_ready;

  genvar gi;
  generate
    for (gi = 0; gi < WARP_CNT; gi++) begin : g_warp
      logic issue_hit, split_hit, join_hit, else_join, fire_hit;
      assign issue_hit = issue_valid && (issue_wid == WARP_CNT_WIDTH'(gi));
      assign split_hit = split_valid && (split_wid == WARP_CNT_WIDTH'(gi));
      assign join_hit  = join_valid  && (join_wid  == WARP_CNT_WIDTH'(gi));
      assign else_join = join_hit && join_is_dvg && join_is_else;
      assign fire_hit  = redir_fire && (grant_idx == WARP_CNT_WIDTH'(gi));

      assign tmask_next[gi*THREAD_CNT +: THREAD_CNT] =
          (split_hit && split_is_dvg) ? split_then_tmask :
          (join_hit && join_is_dvg)   ? join_tmask       :
                                        tmask_reg[gi*THREAD_CNT +: THREAD_CNT];
      // An else-join keeps the warp parked until the scheduler takes its redirect.
      assign stalled_next[gi] = issue_hit || else_join ||
                                (stalled_reg[gi] && !split_hit && !join_hit && !fire_hit);
      assign pending_next[gi] = else_join || (pending_reg[gi] && !fire_hit);
      assign pc_next[gi]      = else_join ? join_pc : pc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      tmask_reg   <= TMASK_RST;
      stalled_reg <= '0;
      pending_reg <= '0;
    end else begin
      tmask_reg   <= tmask_next;
      stalled_reg <= stalled_next;
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WARP_CNT; w++) begin
      pc_reg[w] <= pc_next[w];
    end
  end

  assign redir_sel    = '{wid: DVG_WID_W'(grant_idx), pc: pc_reg[grant_idx]};
  assign warp_tmask   = tmask_reg;
  assign warp_stalled = stalled_reg;
  assign redir_valid  = grant_valid;
  assign redir_wid    = WARP_CNT_WIDTH'(redir_sel.wid);
  assign redir_pc     = redir_sel.pc;

`ifdef DVG_CTL_PERF_EN
  logic [31:0] perf_splits_reg, perf_redirs_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_splits_reg <= '0;
      perf_redirs_reg <= '0;
    end else begin
      perf_splits_reg <= perf_splits_reg + 32'(split_valid && split_is_dvg);
      perf_redirs_reg <= perf_redirs_reg + 32'(redir_fire);
    end
  end

  assign perf_dvg_splits  = perf_splits_reg;
  assign perf_else_redirs = perf_redirs_reg;
`endif

  // Same-warp conflicts cannot be resolved consistently and indicate an upstream bug.
  a_split_join_same_warp: assert property (@(posedge clk) disable iff (reset)
    !(split_valid && join_valid && (split_wid == join_wid)));
  a_issue_stalled_warp: assert property (@(posedge clk) disable iff (reset)
    issue_valid |-> !stalled_reg[issue_wid]);
  a_join_pending_warp: assert property (@(posedge clk) disable iff (reset)
    join_valid |-> !pending_reg[join_wid]);

endmodule

// File: tb/tb_vx_dvg_mask_ctl.sv
// Self-checking bench for vx_dvg_mask_ctl: directed scenarios plus a randomized run
// against a per-warp behavioural model.
module tb_vx_dvg_mask_ctl;

  localparam int T  = 4;
  localparam int W  = 4;
  localparam int WW = 2;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [WW-1:0] issue_wid;
  logic          split_valid;
  logic [WW-1:0] split_wid;
  logic          split_is_dvg;
  logic [T-1:0]  split_then_tmask;
  logic          join_valid;
  logic          join_is_dvg;
  logic          join_is_else;
  logic [WW-1:0] join_wid;
  logic [T-1:0]  join_tmask;
  logic [XL-1:0] join_pc;
  logic [W*T-1:0] warp_tmask;
  logic [W-1:0]  warp_stalled;
  logic          redir_valid;
  logic          redir_ready;
  logic [WW-1:0] redir_wid;
  logic [XL-1:0] redir_pc;
`ifdef DVG_CTL_PERF_EN
  logic [31:0]   perf_dvg_splits;
  logic [31:0]   perf_else_redirs;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [T-1:0]  m_tmask   [W];
  bit            m_stalled [W];
  bit            m_pending [W];
  logic [XL-1:0] m_pc      [W];
  int            m_ptr;
  int            m_held;
  int unsigned   m_splits;
  int unsigned   m_fires;

  always #5 clk = ~clk;

  vx_dvg_mask_ctl #(
    .THREAD_CNT     (T),
    .WARP_CNT       (W),
    .WARP_CNT_WIDTH (WW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_wid        (issue_wid),
    .split_valid      (split_valid),
    .split_wid        (split_wid),
    .split_is_dvg     (split_is_dvg),
    .split_then_tmask (split_then_tmask),
    .join_valid       (join_valid),
    .join_is_dvg      (join_is_dvg),
    .join_is_else     (join_is_else),
    .join_wid         (join_wid),
    .join_tmask       (join_tmask),
    .join_pc          (join_pc),
    .warp_tmask       (warp_tmask),
    .warp_stalled     (warp_stalled),
    .redir_valid      (redir_valid),
    .redir_ready      (redir_ready),
    .redir_wid        (redir_wid),
    .redir_pc         (redir_pc)
`ifdef DVG_CTL_PERF_EN
    ,
    .perf_dvg_splits  (perf_dvg_splits),
    .perf_else_redirs (perf_else_redirs)
`endif
  );

  // Redirect the scheduler should currently see: a warp left waiting by back-pressure
  // stays offered; otherwise the first pending warp at or after the pointer.
  function automatic int model_grant();
    if (m_held >= 0) return m_held;
    for (int i = 0; i < W; i++) begin
      int j = (m_ptr + i) % W;
      if (m_pending[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_update();
    int g;
    g = model_grant();
    if (reset) begin
      for (int w = 0; w < W; w++) begin
        m_tmask[w]   = (w == 0) ? T'(1) : '0;
        m_stalled[w] = 1'b0;
        m_pending[w] = 1'b0;
      end
      m_ptr = 0; m_held = -1; m_splits = 0; m_fires = 0;
      return;
    end
    if (split_valid) begin
      if (split_is_dvg) begin
        m_tmask[split_wid] = split_then_tmask;
        m_splits++;
      end
      m_stalled[split_wid] = 1'b0;
    end
    if (join_valid) begin
      if (join_is_dvg) m_tmask[join_wid] = join_tmask;
      if (join_is_dvg && join_is_else) begin
        m_pending[join_wid] = 1'b1;
        m_pc[join_wid]      = join_pc;
        m_stalled[join_wid] = 1'b1;
      end else begin
        m_stalled[join_wid] = 1'b0;
      end
    end
    if (g >= 0 && redir_ready) begin
      m_pending[g] = 1'b0;
      m_stalled[g] = 1'b0;
      m_ptr        = (g + 1) % W;
      m_fires++;
      m_held       = -1;
    end else begin
      m_held = g;
    end
    if (issue_valid) m_stalled[issue_wid] = 1'b1;
  endfunction

  task automatic clear_inputs();
    issue_valid = 0; issue_wid = '0;
    split_valid = 0; split_wid = '0; split_is_dvg = 0; split_then_tmask = '0;
    join_valid = 0; join_is_dvg = 0; join_is_else = 0; join_wid = '0;
    join_tmask = '0; join_pc = '0;
  endtask

  // Apply the currently driven inputs for one clock edge; outputs are sampled at the following negedge.
  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    @(negedge clk);
    $display("[%0t] %-10s rst=%0b iss=%0b/%0d spl=%0b/%0d dvg=%0b jn=%0b/%0d dvg=%0b else=%0b rdy=%0b | tm=%h st=%b rv=%0b rw=%0d rpc=%h",
             $time, tag, reset, issue_valid, issue_wid, split_valid, split_wid, split_is_dvg,
             join_valid, join_wid, join_is_dvg, join_is_else, redir_ready,
             warp_tmask, warp_stalled, redir_valid, redir_wid, redir_pc);
    clear_inputs();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; redir_ready = 0;
    clear_inputs();
    step("reset");
    reset = 1;
    step("reset");
    checks++; if (warp_tmask !== 16'h0001) begin errors++; $display("FAIL reset_tmask: got %h want 0001", warp_tmask); end
    checks++; if (warp_stalled !== 4'b0000) begin errors++; $display("FAIL reset_stalled: got %b want 0000", warp_stalled); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid: got %b want 0", redir_valid); end
`ifdef DVG_CTL_PERF_EN
    checks++; if (perf_dvg_splits !== 32'd0 || perf_else_redirs !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_dvg_splits, perf_else_redirs); end
`endif
  endtask

  task automatic test_split();
    issue_valid = 1; issue_wid = 2'd1;
    step("issue");
    checks++; if (warp_stalled[1] !== 1'b1) begin errors++; $display("FAIL split_stall_set: got %b want 1", warp_stalled[1]); end
    split_valid = 1; split_wid = 2'd1; split_is_dvg = 1; split_then_tmask = 4'h3;
    step("split");
    checks++; if (warp_stalled[1] !== 1'b0) begin errors++; $display("FAIL split_stall_clr: got %b want 0", warp_stalled[1]); end
    checks++; if (warp_tmask[1*T +: T] !== 4'h3) begin errors++; $display("FAIL split_tmask: got %h want 3", warp_tmask[1*T +: T]); end
    checks++; if (warp_tmask[0*T +: T] !== 4'h1) begin errors++; $display("FAIL split_other_warp: got %h want 1", warp_tmask[0*T +: T]); end
  endtask

  task automatic test_else_join();
    issue_valid = 1; issue_wid = 2'd1;
    step("issue");
    join_valid = 1; join_wid = 2'd1; join_is_dvg = 1; join_is_else = 1;
    join_tmask = 4'hC; join_pc = 32'h8000_0100; redir_ready = 1;
    step("else_join");
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL else_redir_valid: got %b want 1", redir_valid); end
    checks++; if (redir_wid !== 2'd1) begin errors++; $display("FAIL else_redir_wid: got %0d want 1", redir_wid); end
    checks++; if (redir_pc !== 32'h8000_0100) begin errors++; $display("FAIL else_redir_pc: got %h want 80000100", redir_pc); end
    checks++; if (warp_tmask[1*T +: T] !== 4'hC) begin errors++; $display("FAIL else_tmask: got %h want c", warp_tmask[1*T +: T]); end
    checks++; if (warp_stalled[1] !== 1'b1) begin errors++; $display("FAIL else_stall_held: got %b want 1", warp_stalled[1]); end
    step("fire");
    checks++; if (warp_stalled[1] !== 1'b0) begin errors++; $display("FAIL else_stall_after_fire: got %b want 0", warp_stalled[1]); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL else_valid_after_fire: got %b want 0", redir_valid); end
  endtask

  task automatic test_reconverge();
    issue_valid = 1; issue_wid = 2'd1;
    step("issue");
    join_valid = 1; join_wid = 2'd1; join_is_dvg = 1; join_is_else = 0; join_tmask = 4'hF;
    step("reconv");
    checks++; if (warp_tmask[1*T +: T] !== 4'hF) begin errors++; $display("FAIL reconv_tmask: got %h want f", warp_tmask[1*T +: T]); end
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL reconv_no_redir: got %b want 0", redir_valid); end
    checks++; if (warp_stalled[1] !== 1'b0) begin errors++; $display("FAIL reconv_stall: got %b want 0", warp_stalled[1]); end
  endtask

  task automatic test_back_to_back();
    redir_ready = 0;
    issue_valid = 1; issue_wid = 2'd2;
    step("issue");
    issue_valid = 1; issue_wid = 2'd3;
    step("issue");
    join_valid = 1; join_wid = 2'd2; join_is_dvg = 1; join_is_else = 1; join_tmask = 4'h5; join_pc = 32'h8000_0200;
    step("else_join");
    join_valid = 1; join_wid = 2'd3; join_is_dvg = 1; join_is_else = 1; join_tmask = 4'hA; join_pc = 32'h8000_0300;
    step("else_join");
    for (int c = 0; c < 3; c++) begin
      checks++; if (redir_valid !== 1'b1 || redir_wid !== 2'd2 || redir_pc !== 32'h8000_0200) begin
        errors++; $display("FAIL b2b_hold[%0d]: got v=%b wid=%0d pc=%h want v=1 wid=2 pc=80000200", c, redir_valid, redir_wid, redir_pc); end
      if (c < 2) step("stall_rdy");
    end
    redir_ready = 1;
    step("fire");
    checks++; if (redir_valid !== 1'b1 || redir_wid !== 2'd3 || redir_pc !== 32'h8000_0300) begin
      errors++; $display("FAIL b2b_second: got v=%b wid=%0d pc=%h want v=1 wid=3 pc=80000300", redir_valid, redir_wid, redir_pc); end
    checks++; if (warp_stalled[3:2] !== 2'b10) begin errors++; $display("FAIL b2b_stall_mid: got %b want 10", warp_stalled[3:2]); end
    step("fire");
    checks++; if (redir_valid !== 1'b0 || warp_stalled[3:2] !== 2'b00) begin
      errors++; $display("FAIL b2b_drained: got v=%b st=%b want v=0 st=00", redir_valid, warp_stalled[3:2]); end
  endtask

  task automatic test_reset_mid();
    redir_ready = 0;
    split_valid = 1; split_wid = 2'd0; split_is_dvg = 1; split_then_tmask = 4'h6;
    issue_valid = 1; issue_wid = 2'd2;
    step("issue_split");
    join_valid = 1; join_wid = 2'd2; join_is_dvg = 1; join_is_else = 1; join_tmask = 4'h9; join_pc = 32'h8000_0400;
    step("else_join");
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b want 1", redir_valid); end
    reset = 1;
    step("reset");
    checks++; if (redir_valid !== 1'b0) begin errors++; $display("FAIL midrst_redir_valid: got %b want 0", redir_valid); end
    checks++; if (warp_tmask !== 16'h0001 || warp_stalled !== 4'b0000) begin
      errors++; $display("FAIL midrst_state: got tm=%h st=%b want tm=0001 st=0000", warp_tmask, warp_stalled); end
`ifdef DVG_CTL_PERF_EN
    checks++; if (perf_dvg_splits !== 32'd0 || perf_else_redirs !== 32'd0) begin
      errors++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", perf_dvg_splits, perf_else_redirs); end
`endif
  endtask

  task automatic test_random();
    int q_iss[$];
    int q_res[$];
    int sw, jw, g;
    for (int cyc = 0; cyc < 300; cyc++) begin
      q_iss.delete(); q_res.delete();
      for (int w = 0; w < W; w++) begin
        if (!m_stalled[w]) q_iss.push_back(w);
        else if (!m_pending[w]) q_res.push_back(w);
      end
      redir_ready = ($urandom_range(0, 2) != 0);
      if (q_iss.size() > 0 && $urandom_range(0, 1) == 1) begin
        issue_valid = 1;
        issue_wid   = WW'(q_iss[$urandom_range(0, q_iss.size() - 1)]);
      end
      sw = -1;
      if (q_res.size() > 0 && $urandom_range(0, 2) == 0) begin
        sw = q_res[$urandom_range(0, q_res.size() - 1)];
        split_valid = 1; split_wid = WW'(sw);
        split_is_dvg = $urandom_range(0, 1) == 1;
        split_then_tmask = T'($urandom);
      end
      if (q_res.size() > 0 && $urandom_range(0, 1) == 1) begin
        jw = q_res[$urandom_range(0, q_res.size() - 1)];
        if (jw != sw) begin
          join_valid = 1; join_wid = WW'(jw);
          join_is_dvg = $urandom_range(0, 3) != 0;
          join_is_else = $urandom_range(0, 1) == 1;
          join_tmask = T'($urandom);
          join_pc = $urandom;
        end
      end
      step("random");
      for (int w = 0; w < W; w++) begin
        checks++; if (warp_tmask[w*T +: T] !== m_tmask[w]) begin
          errors++; $display("FAIL rnd_tmask[%0d] cyc %0d: got %h want %h", w, cyc, warp_tmask[w*T +: T], m_tmask[w]); end
        checks++; if (warp_stalled[w] !== m_stalled[w]) begin
          errors++; $display("FAIL rnd_stalled[%0d] cyc %0d: got %b want %b", w, cyc, warp_stalled[w], m_stalled[w]); end
      end
      g = model_grant();
      checks++; if (redir_valid !== (g >= 0)) begin
        errors++; $display("FAIL rnd_redir_valid cyc %0d: got %b want %b", cyc, redir_valid, g >= 0); end
      if (g >= 0) begin
        checks++; if (redir_wid !== WW'(g) || redir_pc !== m_pc[g]) begin
          errors++; $display("FAIL rnd_redir cyc %0d: got wid=%0d pc=%h want wid=%0d pc=%h", cyc, redir_wid, redir_pc, g, m_pc[g]); end
      end
`ifdef DVG_CTL_PERF_EN
      checks++; if (perf_dvg_splits !== m_splits || perf_else_redirs !== m_fires) begin
        errors++; $display("FAIL rnd_perf cyc %0d: got %0d/%0d want %0d/%0d", cyc, perf_dvg_splits, perf_else_redirs, m_splits, m_fires); end
`endif
    end
  endtask

  initial begin
    m_held = -1; m_ptr = 0;
    test_reset();
    test_split();
    test_else_join();
    test_reconverge();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
